// File: rtl/reloj_soc_nios_mul_combine.sv
// Final combine stage of the Nios II multiplier: folds three 16x16 partial products into the
// low 32 bits of the product over a two-register valid/ready pipeline.
// Optional truncation flag output is enabled by defining MUL_COMBINE_TRUNC_FLAG_EN.
module reloj_soc_nios_mul_combine #(
    parameter int                 TAG_W     = 5,
    parameter logic [TAG_W-1:0]   RESET_TAG = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_p1,
    input  logic [31:0]        in_p2,
    input  logic [31:0]        in_p3,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_result,
`ifdef MUL_COMBINE_TRUNC_FLAG_EN
    output logic               out_trunc,
`endif
    output logic [TAG_W-1:0]   out_tag
);

    logic             a_valid_q, a_valid_d;
    logic [31:0]      a_p1_q, a_p1_d;
    logic [15:0]      a_mid_q, a_mid_d;
    logic [TAG_W-1:0] a_tag_q, a_tag_d;
    logic             b_valid_q, b_valid_d;
    logic [31:0]      b_result_q, b_result_d;
    logic [TAG_W-1:0] b_tag_q, b_tag_d;

    logic             a_adv;
    logic             b_xfer;
    logic             in_xfer;
    logic [16:0]      mid_sum;
    logic [32:0]      b_sum;

    // Only the low halves of p2/p3 can reach bits 31:16 of the product.
    always_comb begin
        b_xfer   = b_valid_q & out_ready;
        a_adv    = a_valid_q & (~b_valid_q | out_ready);
        in_ready = ~flush & (~a_valid_q | ~b_valid_q | out_ready);
        in_xfer  = in_valid & in_ready;
        mid_sum  = {1'b0, in_p2[15:0]} + {1'b0, in_p3[15:0]};
        b_sum    = {1'b0, a_p1_q} + {1'b0, a_mid_q, 16'h0000};
    end

    always_comb begin
        a_p1_d     = a_p1_q;
        a_mid_d    = a_mid_q;
        a_tag_d    = a_tag_q;
        b_result_d = b_result_q;
        b_tag_d    = b_tag_q;
        if (in_xfer) begin
            a_p1_d  = in_p1;
            a_mid_d = mid_sum[15:0];
            a_tag_d = in_tag;
        end
        if (a_adv) begin
            b_result_d = b_sum[31:0];
            b_tag_d    = a_tag_q;
        end
        a_valid_d = in_xfer | (a_valid_q & ~a_adv);
        b_valid_d = a_adv | (b_valid_q & ~b_xfer);
        // A kill drops valids only; stale data is harmless once valid is clear.
        if (flush) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_q  <= 1'b0;
            a_p1_q     <= '0;
            a_mid_q    <= '0;
            a_tag_q    <= RESET_TAG;
            b_valid_q  <= 1'b0;
            b_result_q <= '0;
            b_tag_q    <= RESET_TAG;
        end else begin
            a_valid_q  <= a_valid_d;
            a_p1_q     <= a_p1_d;
            a_mid_q    <= a_mid_d;
            a_tag_q    <= a_tag_d;
            b_valid_q  <= b_valid_d;
            b_result_q <= b_result_d;
            b_tag_q    <= b_tag_d;
        end
    end

    assign out_valid  = b_valid_q;
    assign out_result = b_result_q;
    assign out_tag    = b_tag_q;

`ifdef MUL_COMBINE_TRUNC_FLAG_EN
    logic a_trunc_q, a_trunc_d;
    logic b_trunc_q, b_trunc_d;

    // Flags partial-product truncation, not exact overflow (hi*hi is never seen here).
    always_comb begin
        a_trunc_d = a_trunc_q;
        b_trunc_d = b_trunc_q;
        if (in_xfer)
            a_trunc_d = (|in_p2[31:16]) | (|in_p3[31:16]) | mid_sum[16];
        if (a_adv)
            b_trunc_d = a_trunc_q | b_sum[32];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_trunc_q <= 1'b0;
            b_trunc_q <= 1'b0;
        end else begin
            a_trunc_q <= a_trunc_d;
            b_trunc_q <= b_trunc_d;
        end
    end

    assign out_trunc = b_trunc_q;
`else
    logic unused_hi_bits;
    assign unused_hi_bits = ^{in_p2[31:16], in_p3[31:16], mid_sum[16], b_sum[32]};
`endif

endmodule
